// File: rtl/pc_seq_if.sv
// pc_seq_if: groups the fetch-control inputs and PC/stack status outputs of
// the program-counter sequencer into a single bundle.
//   master modport: drives stall/jump/branch/call/ret controls, next, offset;
//                   observes PC_counter, halted, ras_empty, ras_full, ras_err.
//   slave modport : the sequencer side (mirror of master).
// Clock and reset are kept as plain ports on the sequencer.
interface pc_seq_if #(
    parameter int PC_W  = 16,
    parameter int OFF_W = 9
);
    logic             stall;
    logic             jump_flag;
    logic             branch_flag;
    logic             call_flag;
    logic             ret_flag;
    logic [PC_W-1:0]  next;
    logic [OFF_W-1:0] offset;
    logic [PC_W-1:0]  PC_counter;
    logic             halted;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_err;

    modport master (
        output stall, jump_flag, branch_flag, call_flag, ret_flag, next, offset,
        input  PC_counter, halted, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  stall, jump_flag, branch_flag, call_flag, ret_flag, next, offset,
        output PC_counter, halted, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer for the instruction-fetch stage.
// Supports increment, absolute jump, PC-relative branch and call/return via a
// small return-address stack (RAS). The PC saturates at LIMIT and parks there.
// Ports:
//   clk        : rising-edge clock
//   pc_reset_n : asynchronous active-low reset
//   bus        : pc_seq_if slave modport (controls in, PC/stack status out)
// Per-cycle priority: stall > ret > call > jump > branch > increment.
module pc_seq #(
    parameter int PC_W       = 16,
    parameter int OFF_W      = 9,
    parameter int LIMIT      = 27,
    parameter int RAS_DEPTH  = 4,
    parameter int RESET_ADDR = 0
) (
    input  logic     clk,
    input  logic     pc_reset_n,
    pc_seq_if.slave  bus
);
    // Two extra bits so PC + signed offset never wraps before clamping.
    localparam int SW    = PC_W + 2;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic signed [SW-1:0] ZERO_S  = '0;
    localparam logic signed [SW-1:0] ONE_S   = SW'(1);
    localparam logic signed [SW-1:0] LIMIT_S = SW'(LIMIT);

    // Saturate a wide signed target into [0, LIMIT].
    function automatic logic [PC_W-1:0] clamp(input logic signed [SW-1:0] t);
        logic [PC_W-1:0] r;
        if (t < ZERO_S) begin
            r = '0;
        end else if (t > LIMIT_S) begin
            r = PC_W'(LIMIT);
        end else begin
            r = t[PC_W-1:0];
        end
        return r;
    endfunction

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [PC_W-1:0]  ras_q [RAS_DEPTH];

    logic signed [SW-1:0] pc_wide_s;
    logic signed [SW-1:0] off_ext_s;
    logic [PC_W-1:0]      ret_addr_s;
    logic [PC_W-1:0]      next_clamped_s;
    logic [PC_W-1:0]      branch_tgt_s;
    logic [PC_W-1:0]      top_s;
    logic                 push_s;
    logic                 empty_s;
    logic                 full_s;

    assign empty_s = (cnt_q == CNT_W'(0));
    assign full_s  = (cnt_q == CNT_W'(RAS_DEPTH));

    // Target arithmetic shared by increment, call, jump and branch.
    always_comb begin
        pc_wide_s      = $signed({2'b00, pc_q});
        off_ext_s      = $signed({{(SW-OFF_W){bus.offset[OFF_W-1]}}, bus.offset});
        ret_addr_s     = clamp(pc_wide_s + ONE_S);
        next_clamped_s = clamp($signed({2'b00, bus.next}));
        branch_tgt_s   = clamp(pc_wide_s + off_ext_s);
    end

    // Top-of-stack read: entry cnt_q-1 holds the most recent return address.
    always_comb begin
        top_s = '0;
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (cnt_q == CNT_W'(i + 1)) begin
                top_s = ras_q[i];
            end else begin
                top_s = top_s;
            end
        end
    end

    // Next-state selection following the fixed action priority.
    always_comb begin
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        push_s = 1'b0;
        if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.ret_flag) begin
            if (!empty_s) begin
                pc_d  = top_s;
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.call_flag) begin
            // The jump is taken even when the stack is full; only the push is lost.
            pc_d = next_clamped_s;
            if (full_s) begin
                err_d = 1'b1;
            end else begin
                push_s = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end else if (bus.jump_flag) begin
            pc_d = next_clamped_s;
        end else if (bus.branch_flag) begin
            pc_d = branch_tgt_s;
        end else begin
            pc_d = ret_addr_s;
        end
    end

    // PC, stack count and sticky error registers.
    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            pc_q  <= PC_W'(RESET_ADDR);
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Return-address stack storage; a push writes at the current count.
    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                if (push_s && (cnt_q == CNT_W'(i))) begin
                    ras_q[i] <= ret_addr_s;
                end
            end
        end
    end

    assign bus.PC_counter = pc_q;
    assign bus.halted     = (pc_q == PC_W'(LIMIT));
    assign bus.ras_empty  = empty_s;
    assign bus.ras_full   = full_s;
    assign bus.ras_err    = err_q;
endmodule
